string_loader: RTL and testbench

//  Host-side programming engine for the string comparator path. Accepts a corrupt-string

---
 rtl/sniffer_pkg.sv | 51 +++++
 rtl/string_loader.sv | 179 +++++++++++++++++
 tb/tb_string_loader.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sniffer_pkg.sv
// sniffer_pkg
// Shared constants, types and helpers for the string comparator path.
//   MAX_CHARS      : comparator string capacity in characters
//   LEN_W          : width of length fields (2**LEN_W > MAX_CHARS)
//   CHAR_W         : bits per character
//   LANES          : characters carried per 32-bit config word
//   WORD_W         : width of the word counter (enough for ceil(MAX_CHARS/LANES))
//   loader_state_t : string_loader FSM states
//   sniff_string_t : committed string, char 0 at index 0
//   byte_keep      : which lanes of a config word fall inside the string length
//   words_needed   : number of config words needed for a given length
package sniffer_pkg;

    localparam int MAX_CHARS = 17;
    localparam int LEN_W     = 5;
    localparam int CHAR_W    = 8;
    localparam int LANES     = 4;
    localparam int WORD_W    = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } loader_state_t;

    typedef logic [0:MAX_CHARS-1][CHAR_W-1:0] sniff_string_t;

    // Bit j of the mask is set when char (LANES*word_idx + j) is below len.
    // Lane 0 is the most significant byte of the config word.
    function automatic logic [LANES-1:0] byte_keep(
        input logic [WORD_W-1:0] word_idx,
        input logic [LEN_W-1:0]  len
    );
        logic [LANES-1:0] keep;
        keep = '0;
        for (int j = 0; j < LANES; j++) begin
            keep[j] = ((int'(word_idx) * LANES + j) < int'(len));
        end
        return keep;
    endfunction

    // ceil(len / LANES); only meaningful for legal lengths 1..MAX_CHARS.
    function automatic logic [WORD_W-1:0] words_needed(
        input logic [LEN_W-1:0] len
    );
        logic [LEN_W:0] sum;
        sum = {1'b0, len} + (LEN_W+1)'(LANES - 1);
        return WORD_W'(sum >> 2);
    endfunction

endpackage

// File: rtl/string_loader.sv
// string_loader
// Host-side programming engine for the string comparator. A string is announced
// with cfg_start/cfg_len, then streamed in as 32-bit words over a valid/ready
// handshake into a shadow buffer. Once the last word lands, the shadow is copied
// to the comparator-facing registers in a single cycle so the comparator never
// sees a half-written string, and the comparator is told to clear.
// Ports:
//   clk         in   system clock
//   n_rst       in   asynchronous reset, active-low
//   cfg_start   in   begin a new string; cfg_len sampled on the same edge
//   cfg_len     in   character count, legal 1..MAX_CHARS
//   cfg_abort   in   discard the load in progress
//   cfg_valid   in   cfg_data valid
//   cfg_data    in   four chars, char 4k in [31:24] down to char 4k+3 in [7:0]
//   cfg_ready   out  loader accepts cfg_data this cycle
//   string_out  out  committed string, char 0 at index 0
//   strlen_out  out  index of last valid char (count - 1)
//   match_en    out  a committed string exists; gates comparator matching
//   cmp_clear   out  one-cycle comparator clear on commit
//   load_done   out  one-cycle pulse when a commit completes
//   load_err    out  one-cycle pulse on an illegal command
module string_loader
    import sniffer_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              cfg_start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_abort,
    input  logic              cfg_valid,
    input  logic [31:0]       cfg_data,
    output logic              cfg_ready,
    output sniff_string_t     string_out,
    output logic [LEN_W-1:0]  strlen_out,
    output logic              match_en,
    output logic              cmp_clear,
    output logic              load_done,
    output logic              load_err
);

    loader_state_t      r_state;
    loader_state_t      w_nextState;

    logic [LEN_W-1:0]   r_len;
    logic [WORD_W-1:0]  r_wordsNeeded;
    logic [WORD_W-1:0]  r_wordCnt;
    sniff_string_t      r_shadow;

    sniff_string_t      r_stringOut;
    logic [LEN_W-1:0]   r_strlen;
    logic               r_matchEn;
    logic               r_cfgReady;
    logic               r_cmpClear;
    logic               r_loadDone;
    logic               r_loadErr;

    logic               w_lenLegal;
    logic               w_handshake;
    logic               w_lastWord;
    logic [LANES-1:0]   w_keep;
    logic               w_readyNext;
    logic               w_errNext;
    logic               w_commit;

    assign w_lenLegal  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_CHARS));
    assign w_handshake = cfg_valid && r_cfgReady;
    assign w_lastWord  = ((r_wordCnt + WORD_W'(1)) == r_wordsNeeded);
    assign w_keep      = byte_keep(r_wordCnt, r_len);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Abort wins over a handshake on the same edge; COMMIT always lasts one cycle.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE: begin
                if (cfg_start && w_lenLegal) begin
                    w_nextState = LOAD;
                end
            end
            LOAD: begin
                if (cfg_abort) begin
                    w_nextState = IDLE;
                end else if (w_handshake && w_lastWord) begin
                    w_nextState = COMMIT;
                end
            end
            COMMIT: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Next values for the registered control outputs. Ready follows the state we
    // are about to enter so it is high exactly while the FSM sits in LOAD.
    always_comb begin
        w_readyNext = (w_nextState == LOAD);
        w_errNext   = cfg_start &&
                      (((r_state == IDLE) && !w_lenLegal) || (r_state == LOAD));
        w_commit    = (r_state == COMMIT);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cfgReady <= 1'b0;
            r_cmpClear <= 1'b0;
            r_loadDone <= 1'b0;
            r_loadErr  <= 1'b0;
        end else begin
            r_cfgReady <= w_readyNext;
            r_cmpClear <= w_commit;
            r_loadDone <= w_commit;
            r_loadErr  <= w_errNext;
        end
    end

    // Shadow assembly and commit copy. The shadow is cleared at start, so lanes
    // masked off by byte_keep simply stay zero.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_len         <= '0;
            r_wordsNeeded <= '0;
            r_wordCnt     <= '0;
            r_shadow      <= '0;
            r_stringOut   <= '0;
            r_strlen      <= '0;
            r_matchEn     <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (cfg_start && w_lenLegal) begin
                        r_len         <= cfg_len;
                        r_wordsNeeded <= words_needed(cfg_len);
                        r_wordCnt     <= '0;
                        r_shadow      <= '0;
                    end
                end
                LOAD: begin
                    if (cfg_abort) begin
                        r_wordCnt <= '0;
                        r_shadow  <= '0;
                    end else if (w_handshake) begin
                        for (int c = 0; c < MAX_CHARS; c++) begin
                            if ((r_wordCnt == WORD_W'(c / LANES)) && w_keep[c % LANES]) begin
                                r_shadow[c] <= cfg_data[(LANES-1-(c % LANES))*CHAR_W +: CHAR_W];
                            end
                        end
                        r_wordCnt <= r_wordCnt + WORD_W'(1);
                    end
                end
                COMMIT: begin
                    r_stringOut <= r_shadow;
                    r_strlen    <= r_len - LEN_W'(1);
                    r_matchEn   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign cfg_ready  = r_cfgReady;
    assign string_out = r_stringOut;
    assign strlen_out = r_strlen;
    assign match_en   = r_matchEn;
    assign cmp_clear  = r_cmpClear;
    assign load_done  = r_loadDone;
    assign load_err   = r_loadErr;

endmodule

// File: tb/tb_string_loader.sv
// tb_string_loader
// Self-checking bench for string_loader. Expected outputs are held in a small
// model (eStr/eLen/eMatch/eReady and pulse flags) that the stimulus code updates
// at each drive point with what the outputs must be after the next clock edge.
// A compare process checks every output against the model shortly after each
// rising edge; directed literal checks pin the model at key points.
module tb_string_loader;
    import sniffer_pkg::*;

    localparam int SW = MAX_CHARS * CHAR_W;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              cfg_start;
    logic [LEN_W-1:0]  cfg_len;
    logic              cfg_abort;
    logic              cfg_valid;
    logic [31:0]       cfg_data;
    logic              cfg_ready;
    sniff_string_t     string_out;
    logic [LEN_W-1:0]  strlen_out;
    logic              match_en;
    logic              cmp_clear;
    logic              load_done;
    logic              load_err;

    sniff_string_t     eStr;
    logic [LEN_W-1:0]  eLen;
    logic              eMatch;
    logic              eReady;
    logic              eClear;
    logic              eDone;
    logic              eErr;

    logic [31:0]       wbuf [5];
    int                checks   = 0;
    int                failures = 0;
    int                hsCount  = 0;
    int                hsBefore;

    always #5 clk = ~clk;

    string_loader dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .cfg_start  (cfg_start),
        .cfg_len    (cfg_len),
        .cfg_abort  (cfg_abort),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready),
        .string_out (string_out),
        .strlen_out (strlen_out),
        .match_en   (match_en),
        .cmp_clear  (cmp_clear),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    task automatic checkOutput(input string name, input logic [SW-1:0] actual,
                               input logic [SW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Expected committed string: the first len chars of the word stream, rest zero.
    function automatic sniff_string_t buildString(input int len);
        sniff_string_t s;
        logic [31:0]   t;
        s = '0;
        for (int c = 0; c < len; c++) begin
            t    = wbuf[c / 4];
            s[c] = t[31 - 8*(c % 4) -: 8];
        end
        return s;
    endfunction

    // Advance to the drive point of the next cycle; pulses default to low.
    task automatic step();
        @(posedge clk);
        #2;
        eClear = 1'b0;
        eDone  = 1'b0;
        eErr   = 1'b0;
    endtask

    task automatic modelReset();
        eStr   = '0;
        eLen   = '0;
        eMatch = 1'b0;
        eReady = 1'b0;
        eClear = 1'b0;
        eDone  = 1'b0;
        eErr   = 1'b0;
    endtask

    // Full load of wbuf[0..] with length len; gaps inserts an idle cycle
    // between words and keeps cfg_valid high through the commit cycle.
    task automatic applyStimulus(input int len, input bit gaps);
        int n;
        n = (len + 3) / 4;
        cfg_start = 1'b1;
        cfg_len   = LEN_W'(len);
        eReady    = 1'b1;
        step();
        cfg_start = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (gaps && k > 0) begin
                cfg_valid = 1'b0;
                eReady    = 1'b1;
                step();
            end
            cfg_valid = 1'b1;
            cfg_data  = wbuf[k];
            eReady    = (k == n - 1) ? 1'b0 : 1'b1;
            step();
        end
        cfg_valid = gaps;
        cfg_data  = 32'hDEADBEEF;
        eStr      = buildString(len);
        eLen      = LEN_W'(len - 1);
        eMatch    = 1'b1;
        eClear    = 1'b1;
        eDone     = 1'b1;
        eReady    = 1'b0;
        step();
        cfg_valid = 1'b0;
        step();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            checkOutput("string_out", SW'(string_out), SW'(eStr));
            checkOutput("strlen_out", SW'(strlen_out), SW'(eLen));
            checkOutput("match_en",   SW'(match_en),   SW'(eMatch));
            checkOutput("cfg_ready",  SW'(cfg_ready),  SW'(eReady));
            checkOutput("cmp_clear",  SW'(cmp_clear),  SW'(eClear));
            checkOutput("load_done",  SW'(load_done),  SW'(eDone));
            checkOutput("load_err",   SW'(load_err),   SW'(eErr));
        end
    end

    always @(negedge clk) begin
        if (n_rst && cfg_valid && cfg_ready) begin
            hsCount++;
        end
    end

    initial begin
        n_rst     = 1'b0;
        cfg_start = 1'b0;
        cfg_len   = '0;
        cfg_abort = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        for (int i = 0; i < 5; i++) wbuf[i] = '0;
        modelReset();

        $display("[TB] reset with random inputs");
        repeat (4) begin
            step();
            cfg_start = 1'($urandom_range(0, 1));
            cfg_len   = LEN_W'($urandom);
            cfg_abort = 1'($urandom_range(0, 1));
            cfg_valid = 1'($urandom_range(0, 1));
            cfg_data  = $urandom;
        end
        step();
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        cfg_valid = 1'b0;
        n_rst     = 1'b1;
        step();
        checkOutput("reset_string", SW'(string_out), SW'(0));
        checkOutput("reset_match",  SW'(match_en),   SW'(0));
        checkOutput("reset_ready",  SW'(cfg_ready),  SW'(0));

        $display("[TB] len=6 ABCDEF");
        wbuf[0] = 32'h41424344;
        wbuf[1] = 32'h4546FFFF;
        applyStimulus(6, 1'b0);
        checkOutput("t2_char0",  SW'(string_out[0]), SW'(8'h41));
        checkOutput("t2_char5",  SW'(string_out[5]), SW'(8'h46));
        checkOutput("t2_char6",  SW'(string_out[6]), SW'(8'h00));
        checkOutput("t2_strlen", SW'(strlen_out),    SW'(5));
        checkOutput("t2_match",  SW'(match_en),      SW'(1));

        $display("[TB] len=17 with gaps");
        wbuf[0] = 32'h30313233;
        wbuf[1] = 32'h34353637;
        wbuf[2] = 32'h38393A3B;
        wbuf[3] = 32'h3C3D3E3F;
        wbuf[4] = 32'h40AABBCC;
        hsBefore = hsCount;
        applyStimulus(17, 1'b1);
        checkOutput("t3_handshakes", SW'(hsCount - hsBefore), SW'(5));
        checkOutput("t3_char15",     SW'(string_out[15]),     SW'(8'h3F));
        checkOutput("t3_char16",     SW'(string_out[16]),     SW'(8'h40));
        checkOutput("t3_strlen",     SW'(strlen_out),         SW'(16));

        $display("[TB] illegal lengths");
        cfg_start = 1'b1;
        cfg_len   = LEN_W'(0);
        eErr      = 1'b1;
        step();
        cfg_start = 1'b0;
        step();
        cfg_start = 1'b1;
        cfg_len   = LEN_W'(18);
        eErr      = 1'b1;
        step();
        cfg_start = 1'b0;
        step();
        checkOutput("t4_strlen", SW'(strlen_out),     SW'(16));
        checkOutput("t4_char16", SW'(string_out[16]), SW'(8'h40));

        $display("[TB] abort keeps committed string");
        wbuf[0] = 32'h41424344;
        applyStimulus(4, 1'b0);
        cfg_start = 1'b1;
        cfg_len   = LEN_W'(8);
        eReady    = 1'b1;
        step();
        cfg_start = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = 32'h45464748;
        eReady    = 1'b1;
        step();
        cfg_valid = 1'b0;
        cfg_start = 1'b1;
        cfg_len   = LEN_W'(3);
        eErr      = 1'b1;
        eReady    = 1'b1;
        step();
        cfg_start = 1'b0;
        cfg_abort = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 32'h494A4B4C;
        eReady    = 1'b0;
        step();
        cfg_abort = 1'b0;
        cfg_valid = 1'b0;
        step();
        checkOutput("t5_char0",  SW'(string_out[0]), SW'(8'h41));
        checkOutput("t5_char3",  SW'(string_out[3]), SW'(8'h44));
        checkOutput("t5_char4",  SW'(string_out[4]), SW'(8'h00));
        checkOutput("t5_strlen", SW'(strlen_out),    SW'(3));
        wbuf[0] = 32'h31323334;
        wbuf[1] = 32'h35363738;
        applyStimulus(8, 1'b0);
        checkOutput("t5_newchar7", SW'(string_out[7]), SW'(8'h38));
        checkOutput("t5_newlen",   SW'(strlen_out),    SW'(7));

        $display("[TB] reset mid-load");
        wbuf[0] = 32'h61626364;
        wbuf[1] = 32'h65666768;
        wbuf[2] = 32'h696A6B6C;
        cfg_start = 1'b1;
        cfg_len   = LEN_W'(12);
        eReady    = 1'b1;
        step();
        cfg_start = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = wbuf[0];
        eReady    = 1'b1;
        step();
        cfg_data  = wbuf[1];
        n_rst     = 1'b0;
        modelReset();
        step();
        step();
        n_rst     = 1'b1;
        cfg_valid = 1'b0;
        step();
        checkOutput("t6_rst_match", SW'(match_en),   SW'(0));
        checkOutput("t6_rst_len",   SW'(strlen_out), SW'(0));
        applyStimulus(12, 1'b0);
        checkOutput("t6_char11", SW'(string_out[11]), SW'(8'h6C));
        checkOutput("t6_char12", SW'(string_out[12]), SW'(8'h00));
        checkOutput("t6_strlen", SW'(strlen_out),     SW'(11));

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
